// File: rtl/signed_bcd_addsub_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// signed_bcd_addsub_ctrl_pkg : state encoding, BCD constants and digit helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package signed_bcd_addsub_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMP  = 3'd1,
    DIG0 = 3'd2,
    DIG1 = 3'd3,
    DIG2 = 3'd4,
    FIN  = 3'd5
  } state_e;

  localparam logic [4:0] BCD_MAX_DIGIT = 5'd9;
  localparam logic [4:0] BCD_RADIX     = 5'd10;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic logic [3:0] bcd_digit(input logic [11:0] v, input logic [1:0] idx);
    logic [3:0] d;
    case (idx)
      2'd0:    d = v[3:0];
      2'd1:    d = v[7:4];
      default: d = v[11:8];
    endcase
    return d;
  endfunction

  function automatic logic has_bad_digit(input logic [11:0] v);
    return ({1'b0, v[3:0]}  > BCD_MAX_DIGIT) ||
           ({1'b0, v[7:4]}  > BCD_MAX_DIGIT) ||
           ({1'b0, v[11:8]} > BCD_MAX_DIGIT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_addsub.sv
// ---------------------------------------------------------------------------
// bcd_digit_addsub : combinational single BCD digit add/subtract with carry
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_digit_addsub
  import signed_bcd_addsub_ctrl_pkg::*;
(
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  input  logic       cin_i,
  input  logic       mode_i,
  output logic [3:0] r_o,
  output logic       cout_o
);

  logic [4:0] sum;
  logic [4:0] diff;

  always_comb begin
    sum    = {1'b0, x_i} + {1'b0, y_i} + {4'd0, cin_i};
    diff   = {1'b0, x_i} - {1'b0, y_i} - {4'd0, cin_i};
    r_o    = 4'd0;
    cout_o = 1'b0;
    if (mode_i == OP_ADD) begin
      if (sum > BCD_MAX_DIGIT) begin
        r_o    = sum[3:0] - BCD_RADIX[3:0];
        cout_o = 1'b1;
      end else begin
        r_o = sum[3:0];
      end
    end else begin
      // Digits are at most 9, so diff lies in -10..9 and bit 4 is the sign.
      if (diff[4]) begin
        r_o    = diff[3:0] + BCD_RADIX[3:0];
        cout_o = 1'b1;
      end else begin
        r_o = diff[3:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mag_cmp12.sv
// ---------------------------------------------------------------------------
// mag_cmp12 : 12-bit unsigned magnitude comparator (L/E/G)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mag_cmp12 (
  input  logic [11:0] a_i,
  input  logic [11:0] b_i,
  output logic        lt_o,
  output logic        eq_o,
  output logic        gt_o
);

  assign lt_o = (a_i <  b_i);
  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i >  b_i);

endmodule

`default_nettype wire

// File: rtl/signed_bcd_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// signed_bcd_addsub_ctrl : signed 3-digit BCD add/sub sequencer, LSD first.
// Optional macro BCD_SAT_EN saturates add overflow to 999.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module signed_bcd_addsub_ctrl
  import signed_bcd_addsub_ctrl_pkg::*;
#(
  parameter int   DIGITS    = 3,
  parameter logic ZERO_SIGN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       op,
  input  logic       SA,
  input  logic [3:0] A2,
  input  logic [3:0] A1,
  input  logic [3:0] A0,
  input  logic       SB,
  input  logic [3:0] B2,
  input  logic [3:0] B1,
  input  logic [3:0] B0,
  output logic       busy,
  output logic       done,
  output logic       SR,
  output logic [3:0] R2,
  output logic [3:0] R1,
  output logic [3:0] R0,
  output logic       ovf,
  output logic       err
);

  localparam logic [1:0] LAST_DIG = 2'(DIGITS - 1);

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [11:0] a_q, a_d;
  logic [11:0] b_q, b_d;
  logic        lt_q, lt_d;
  logic        eq_q, eq_d;
  logic        gt_q, gt_d;
  logic        eff_sub_q, eff_sub_d;
  logic        c_q, c_d;
  logic [11:0] r_q, r_d;
  logic        sr_q, sr_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;

  logic        cmp_lt, cmp_eq, cmp_gt;
  logic        swap;
  logic        sign_sel;
  logic [1:0]  dig_idx;
  logic [3:0]  x_dig, y_dig, dig_r;
  logic        dig_c;
  logic        dig_mode;
  logic [11:0] r_cur;
  logic        ovf_add;

  mag_cmp12 u_cmp (
    .a_i  (a_q),
    .b_i  (b_q),
    .lt_o (cmp_lt),
    .eq_o (cmp_eq),
    .gt_o (cmp_gt)
  );

  // Subtracting the smaller magnitude from the larger keeps the final borrow at 0.
  assign swap     = eff_sub_q & lt_q & ~(eq_q | gt_q);
  assign sign_sel = swap ? (sb_q ^ op_q) : sa_q;
  assign dig_mode = eff_sub_q ? OP_SUB : OP_ADD;

  always_comb begin
    case (state_q)
      DIG1:    dig_idx = 2'd1;
      DIG2:    dig_idx = 2'd2;
      default: dig_idx = 2'd0;
    endcase
  end

  assign x_dig = bcd_digit(swap ? b_q : a_q, dig_idx);
  assign y_dig = bcd_digit(swap ? a_q : b_q, dig_idx);

  bcd_digit_addsub u_digit (
    .x_i    (x_dig),
    .y_i    (y_dig),
    .cin_i  (c_q),
    .mode_i (dig_mode),
    .r_o    (dig_r),
    .cout_o (dig_c)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    a_d       = a_q;
    b_d       = b_q;
    lt_d      = lt_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    eff_sub_d = eff_sub_q;
    c_d       = c_q;
    r_d       = r_q;
    sr_d      = sr_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    ovf_add   = 1'b0;
    r_cur     = r_q;

    case (dig_idx)
      2'd0:    r_cur[3:0]  = dig_r;
      2'd1:    r_cur[7:4]  = dig_r;
      default: r_cur[11:8] = dig_r;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          sa_d    = SA;
          sb_d    = SB;
          a_d     = {A2, A1, A0};
          b_d     = {B2, B1, B0};
          r_d     = 12'd0;
          sr_d    = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = CMP;
        end
      end
      CMP: begin
        lt_d = cmp_lt;
        eq_d = cmp_eq;
        gt_d = cmp_gt;
        c_d  = 1'b0;
        if (has_bad_digit(a_q) || has_bad_digit(b_q)) begin
          err_d   = 1'b1;
          r_d     = 12'd0;
          sr_d    = ZERO_SIGN;
          ovf_d   = 1'b0;
          state_d = FIN;
        end else begin
          eff_sub_d = (op_q == OP_SUB) ^ sa_q ^ sb_q;
          state_d   = DIG0;
        end
      end
      DIG0, DIG1, DIG2: begin
        r_d = r_cur;
        c_d = dig_c;
        if (dig_idx == LAST_DIG) begin
          ovf_add = ~eff_sub_q & dig_c;
          ovf_d   = ovf_add;
`ifdef BCD_SAT_EN
          if (ovf_add) begin
            r_d = 12'h999;
          end
`endif
          sr_d    = (r_d == 12'd0) ? ZERO_SIGN : sign_sel;
          state_d = FIN;
        end else begin
          state_d = (state_q == DIG0) ? DIG1 : DIG2;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      a_q       <= 12'd0;
      b_q       <= 12'd0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      eff_sub_q <= 1'b0;
      c_q       <= 1'b0;
      r_q       <= 12'd0;
      sr_q      <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      a_q       <= a_d;
      b_q       <= b_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      eff_sub_q <= eff_sub_d;
      c_q       <= c_d;
      r_q       <= r_d;
      sr_q      <= sr_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == FIN);
  assign SR   = sr_q;
  assign R2   = r_q[11:8];
  assign R1   = r_q[7:4];
  assign R0   = r_q[3:0];
  assign ovf  = ovf_q;
  assign err  = err_q;

endmodule

`default_nettype wire

// File: doc/signed_bcd_addsub_ctrl.md
Name: signed_bcd_addsub_ctrl

Overview:
Sequencing controller for the signed 3-digit BCD add/subtract path. It accepts two sign-magnitude BCD operands and an operation. It uses one cycle on the existing 12-bit magnitude comparator to choose the operand order and result sign, then runs a digit-serial BCD add or subtract over three cycles, least significant digit first. It sits between the operand-entry logic and the result display/register stage.

Parameters:
DIGITS, 3, number of BCD digits processed. Fixed at 3; the port list is written for 3 digits.
ZERO_SIGN, 0, sign bit driven on SR when the result magnitude is 000. This prevents a negative zero.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
op  input  1  0 = A+B, 1 = A-B
SA  input  1  sign of A (1 = negative)
A2,A1,A0  input  4 each  BCD magnitude of A, with A2 the MSD
SB  input  1  sign of B
B2,B1,B0  input  4 each  BCD magnitude of B
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse in FIN
SR  output  1  result sign
R2,R1,R0  output  4 each  BCD result magnitude
ovf  output  1  result magnitude exceeded 999
err  output  1  a non-BCD digit (>9) was present on an input

Behaviour:
- Reset: state=IDLE; busy, done, SR, ovf and err = 0; R2..R0 = 0; internal carry/borrow and operand registers = 0. Reset applied in any state, mid-operation included, aborts the operation and no done is produced.
- IDLE: when start=1, latch op, SA, SB, A*, B* and move to CMP. While not in IDLE, start and all operand inputs are ignored.
- CMP (1 cycle):
  - Drive the latched magnitudes into the comparator and register L/E/G.
  - If any of the six digits is >9: set err=1, set R=000, SR=ZERO_SIGN, ovf=0, and go to FIN.
  - Otherwise compute eff_sub = op ^ SA ^ SB and go to DIG0.
- Operand routing:
  - eff_sub=0: X=A, Y=B; add; SR=SA.
  - eff_sub=1 and (G or E): X=A, Y=B; subtract; SR=SA.
  - eff_sub=1 and L: X=B, Y=A; subtract; SR=SB^op.
- DIG0, DIG1, DIG2: one digit per cycle, digit i in DIGi. Carry/borrow is cleared entering DIG0.
  - Add: s = Xi + Yi + c. If s>9, then Ri = s-10 and c=1; otherwise Ri = s and c=0.
  - Subtract: d = Xi - Yi - b. If d<0, then Ri = d+10 and b=1; otherwise Ri = d and b=0.
  - Intermediate sums use 5 bits.
- After DIG2:
  - ovf = final carry in add mode only. The result wraps modulo 1000.
  - Final borrow is always 0 by construction.
  - If R2..R0 = 000, then SR = ZERO_SIGN.
  - Go to FIN.
- FIN (1 cycle): done=1, busy=1; next state is IDLE.
- Outputs are valid from FIN and hold until the next start is accepted. They are cleared to 0 on the CMP entry of the next operation.
- Latency:
  - Normal path: start sampled at edge k gives done high in the cycle after edge k+4.
  - err path: done high in the cycle after edge k+1.
- A start held high through FIN is accepted on the first IDLE cycle, which allows back-to-back operations.

Optional Feature:
BCD_SAT_EN
- Defined: on add overflow, R2..R0 are forced to 9,9,9 and ovf=1.
- Undefined: the result wraps modulo 1000 with ovf=1.
- Subtract and err behaviour are identical in both builds.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=0, CMP=1, DIG0=2, DIG1=3, DIG2=4, FIN=5 (3-bit);
  - BCD_MAX_DIGIT=9 and BCD_RADIX=10;
  - OP_ADD=0 and OP_SUB=1.
- One natural sub-module, bcd_digit_addsub: a combinational single-digit add/subtract with carry/borrow in and out, reused across the three digit cycles.
- The existing 12-bit comparator is instantiated unchanged.

Test Plan:
1. +826 + +749, op=0 -> R=575, ovf=1, SR=0, err=0; done in the cycle after edge k+4; busy high for 5 cycles.
2. +126 - +749, op=1 -> L path; R=623, SR=1, ovf=0.
3. -126 + +126, op=0 -> eff_sub=1, E path; R=000, SR=0 (no negative zero).
4. A1=4'hA with any other operands -> err=1, R=000, ovf=0; done in the cycle after edge k+1.
5. -300 - -450, op=1 -> R=150, SR=0. Pulse start in DIG0 -> ignored. Assert rst during DIG1 -> next cycle IDLE with all outputs 0 and no done.
6. With BCD_SAT_EN defined: +826 + +749 -> R=999, ovf=1. Back-to-back case: start held high through FIN -> second operation's CMP occurs in the cycle after IDLE.
